// File: rtl/axi4l_mem_sub.sv
// AXI4-Lite subordinate backed by a word-addressed memory with byte strobes.
// AW, W and AR each sit in a one-entry holding register; B and R are registered.
module axi4l_mem_sub #(
    parameter int unsigned           ADDR_WIDTH = 32,
    parameter int unsigned           DATA_WIDTH = 32,
    parameter int unsigned           MEM_DEPTH  = 1024,
    parameter logic [ADDR_WIDTH-1:0] BASE_ADDR  = '0,
    parameter type axi_req_t = struct packed {
        struct packed {
            logic [ADDR_WIDTH-1:0] addr;
            logic [2:0]            prot;
        } aw;
        logic aw_valid;
        struct packed {
            logic [DATA_WIDTH-1:0]   data;
            logic [DATA_WIDTH/8-1:0] strb;
        } w;
        logic w_valid;
        logic b_ready;
        struct packed {
            logic [ADDR_WIDTH-1:0] addr;
            logic [2:0]            prot;
        } ar;
        logic ar_valid;
        logic r_ready;
    },
    parameter type axi_resp_t = struct packed {
        logic aw_ready;
        logic w_ready;
        struct packed {
            logic [1:0] resp;
        } b;
        logic b_valid;
        logic ar_ready;
        struct packed {
            logic [DATA_WIDTH-1:0] data;
            logic [1:0]            resp;
        } r;
        logic r_valid;
    }
) (
    input  logic      clk_i,
    input  logic      arst_ni,
    input  axi_req_t  req_i,
    output axi_resp_t resp_o
);

    localparam int unsigned STRB_W = DATA_WIDTH / 8;
    localparam int unsigned OFF_W  = $clog2(STRB_W);
    localparam int unsigned IDX_W  = $clog2(MEM_DEPTH);

    localparam logic [1:0] RESP_OKAY   = 2'b00;
    localparam logic [1:0] RESP_SLVERR = 2'b10;

    if (!(DATA_WIDTH == 32 || DATA_WIDTH == 64)) begin : g_bad_data_width
        $error("axi4l_mem_sub: DATA_WIDTH must be 32 or 64");
    end
    if (MEM_DEPTH < 2 || (MEM_DEPTH & (MEM_DEPTH - 1)) != 0) begin : g_bad_mem_depth
        $error("axi4l_mem_sub: MEM_DEPTH must be a power of two >= 2");
    end

    logic                  aw_full, w_full, ar_full;
    logic [ADDR_WIDTH-1:0] aw_addr, ar_addr;
    logic [2:0]            aw_prot, ar_prot;
    logic [DATA_WIDTH-1:0] w_data;
    logic [STRB_W-1:0]     w_strb;

    logic                  b_valid;
    logic [1:0]            b_resp;
    logic                  r_valid;
    logic [DATA_WIDTH-1:0] r_data;
    logic [1:0]            r_resp;

    logic [DATA_WIDTH-1:0] mem [MEM_DEPTH];

    logic                  aw_hs, w_hs, ar_hs;
    logic                  wr_go, rd_go;
    logic [ADDR_WIDTH-1:0] wr_off, rd_off;
    logic                  wr_hit, rd_hit;
    logic [IDX_W-1:0]      wr_idx, rd_idx;

    // Readies come from holding-register state only, never from valid.
    assign aw_hs = req_i.aw_valid & ~aw_full;
    assign w_hs  = req_i.w_valid & ~w_full;
    assign ar_hs = req_i.ar_valid & ~ar_full;

    assign wr_go = aw_full & w_full & (~b_valid | req_i.b_ready);
    assign rd_go = ar_full & (~r_valid | req_i.r_ready);

    // Bits above the window must be zero after rebasing; an underflow wraps high.
    assign wr_off = aw_addr - BASE_ADDR;
    assign rd_off = ar_addr - BASE_ADDR;
    assign wr_hit = (aw_addr >= BASE_ADDR) && ((wr_off >> (OFF_W + IDX_W)) == '0);
    assign rd_hit = (ar_addr >= BASE_ADDR) && ((rd_off >> (OFF_W + IDX_W)) == '0);
    assign wr_idx = wr_off[OFF_W +: IDX_W];
    assign rd_idx = rd_off[OFF_W +: IDX_W];

    always_ff @(posedge clk_i or negedge arst_ni) begin
        if (!arst_ni) begin
            aw_full <= 1'b0;
            aw_addr <= '0;
            aw_prot <= '0;
            w_full  <= 1'b0;
            w_data  <= '0;
            w_strb  <= '0;
            ar_full <= 1'b0;
            ar_addr <= '0;
            ar_prot <= '0;
        end else begin
            if (aw_hs) begin
                aw_full <= 1'b1;
                aw_addr <= req_i.aw.addr;
                aw_prot <= req_i.aw.prot;
            end else if (wr_go) begin
                aw_full <= 1'b0;
            end
            if (w_hs) begin
                w_full <= 1'b1;
                w_data <= req_i.w.data;
                w_strb <= req_i.w.strb;
            end else if (wr_go) begin
                w_full <= 1'b0;
            end
            if (ar_hs) begin
                ar_full <= 1'b1;
                ar_addr <= req_i.ar.addr;
                ar_prot <= req_i.ar.prot;
            end else if (rd_go) begin
                ar_full <= 1'b0;
            end
        end
    end

    always_ff @(posedge clk_i or negedge arst_ni) begin
        if (!arst_ni) begin
            b_valid <= 1'b0;
            b_resp  <= RESP_OKAY;
        end else if (wr_go) begin
            b_valid <= 1'b1;
            b_resp  <= wr_hit ? RESP_OKAY : RESP_SLVERR;
        end else if (req_i.b_ready) begin
            b_valid <= 1'b0;
        end
    end

    // Reads sample mem before this edge's write lands, so same-edge reads see old data.
    always_ff @(posedge clk_i or negedge arst_ni) begin
        if (!arst_ni) begin
            r_valid <= 1'b0;
            r_data  <= '0;
            r_resp  <= RESP_OKAY;
        end else if (rd_go) begin
            r_valid <= 1'b1;
            r_data  <= rd_hit ? mem[rd_idx] : '0;
            r_resp  <= rd_hit ? RESP_OKAY : RESP_SLVERR;
        end else if (req_i.r_ready) begin
            r_valid <= 1'b0;
        end
    end

    always_ff @(posedge clk_i) begin
        if (wr_go && wr_hit) begin
            for (int i = 0; i < int'(STRB_W); i++) begin
                if (w_strb[i]) begin
                    mem[wr_idx][8*i +: 8] <= w_data[8*i +: 8];
                end
            end
        end
    end

    always_comb begin
        resp_o          = '0;
        resp_o.aw_ready = ~aw_full;
        resp_o.w_ready  = ~w_full;
        resp_o.ar_ready = ~ar_full;
        resp_o.b_valid  = b_valid;
        resp_o.b.resp   = b_resp;
        resp_o.r_valid  = r_valid;
        resp_o.r.data   = r_data;
        resp_o.r.resp   = r_resp;
    end

    logic unused_bits;
    assign unused_bits = ^{aw_prot, ar_prot, wr_off[OFF_W-1:0], rd_off[OFF_W-1:0]};

endmodule

// File: tb/tb_axi4l_mem_sub.sv
// Directed bench for axi4l_mem_sub: handshakes, strobes, backpressure, decode, reset.
module tb_axi4l_mem_sub;

    typedef struct packed {
        logic [31:0] addr;
        logic [2:0]  prot;
    } ax_t;
    typedef struct packed {
        logic [31:0] data;
        logic [3:0]  strb;
    } w_t;
    typedef struct packed {
        logic [1:0] resp;
    } b_t;
    typedef struct packed {
        logic [31:0] data;
        logic [1:0]  resp;
    } r_t;
    typedef struct packed {
        ax_t  aw;
        logic aw_valid;
        w_t   w;
        logic w_valid;
        logic b_ready;
        ax_t  ar;
        logic ar_valid;
        logic r_ready;
    } req_t;
    typedef struct packed {
        logic aw_ready;
        logic w_ready;
        b_t   b;
        logic b_valid;
        logic ar_ready;
        r_t   r;
        logic r_valid;
    } resp_t;

    logic  clk;
    logic  arst_n;
    req_t  req;
    resp_t rsp;

    int n_cmp;
    int n_err;

    logic [1:0]  bresp;
    logic [1:0]  rresp;
    logic [31:0] rdata;

    axi4l_mem_sub #(
        .ADDR_WIDTH (32),
        .DATA_WIDTH (32),
        .MEM_DEPTH  (1024),
        .BASE_ADDR  (32'h0),
        .axi_req_t  (req_t),
        .axi_resp_t (resp_t)
    ) dut (
        .clk_i   (clk),
        .arst_ni (arst_n),
        .req_i   (req),
        .resp_o  (rsp)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish (got timeout, required $finish)");
        $fatal(1, "watchdog");
    end

    task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%08h, expected 0x%08h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic do_write(input logic [31:0] addr, input logic [31:0] data,
                            input logic [3:0] strb, output logic [1:0] resp);
        logic aw_done, w_done, got_b, aw_hs, w_hs;
        req.aw.addr  = addr;
        req.aw.prot  = 3'b000;
        req.aw_valid = 1'b1;
        req.w.data   = data;
        req.w.strb   = strb;
        req.w_valid  = 1'b1;
        req.b_ready  = 1'b1;
        aw_done = 1'b0;
        w_done  = 1'b0;
        for (int i = 0; i < 20 && !(aw_done && w_done); i++) begin
            aw_hs = req.aw_valid && rsp.aw_ready;
            w_hs  = req.w_valid && rsp.w_ready;
            step();
            if (aw_hs) begin
                req.aw_valid = 1'b0;
                aw_done = 1'b1;
            end
            if (w_hs) begin
                req.w_valid = 1'b0;
                w_done = 1'b1;
            end
        end
        req.aw_valid = 1'b0;
        req.w_valid  = 1'b0;
        check_eq("wr_handshake", {30'd0, aw_done, w_done}, 32'd3);
        got_b = 1'b0;
        resp  = 2'bxx;
        for (int i = 0; i < 20 && !got_b; i++) begin
            if (rsp.b_valid) begin
                got_b = 1'b1;
                resp  = rsp.b.resp;
            end
            step();
        end
        check_eq("wr_b_seen", {31'd0, got_b}, 32'd1);
    endtask

    task automatic do_read(input logic [31:0] addr, output logic [31:0] data,
                           output logic [1:0] resp);
        logic ar_done, got_r, ar_hs;
        req.ar.addr  = addr;
        req.ar.prot  = 3'b000;
        req.ar_valid = 1'b1;
        req.r_ready  = 1'b1;
        ar_done = 1'b0;
        for (int i = 0; i < 20 && !ar_done; i++) begin
            ar_hs = req.ar_valid && rsp.ar_ready;
            step();
            if (ar_hs) begin
                req.ar_valid = 1'b0;
                ar_done = 1'b1;
            end
        end
        req.ar_valid = 1'b0;
        check_eq("rd_handshake", {31'd0, ar_done}, 32'd1);
        got_r = 1'b0;
        data  = 'x;
        resp  = 2'bxx;
        for (int i = 0; i < 20 && !got_r; i++) begin
            if (rsp.r_valid) begin
                got_r = 1'b1;
                data  = rsp.r.data;
                resp  = rsp.r.resp;
            end
            step();
        end
        check_eq("rd_r_seen", {31'd0, got_r}, 32'd1);
    endtask

    initial begin
        n_cmp  = 0;
        n_err  = 0;
        req    = '0;
        arst_n = 1'b0;

        // Reset state
        #2;
        check_eq("rst_b_valid", {31'd0, rsp.b_valid}, 32'd0);
        check_eq("rst_r_valid", {31'd0, rsp.r_valid}, 32'd0);
        check_eq("rst_b_resp", {30'd0, rsp.b.resp}, 32'd0);
        check_eq("rst_r_resp", {30'd0, rsp.r.resp}, 32'd0);
        check_eq("rst_r_data", rsp.r.data, 32'd0);
        #20;
        arst_n = 1'b1;
        step();
        check_eq("rst_readies", {29'd0, rsp.aw_ready, rsp.w_ready, rsp.ar_ready}, 32'd7);

        // 1: AW and W together, exact B and R latency
        req.aw.addr  = 32'h10;
        req.aw_valid = 1'b1;
        req.w.data   = 32'hDEADBEEF;
        req.w.strb   = 4'hF;
        req.w_valid  = 1'b1;
        req.b_ready  = 1'b1;
        step();
        req.aw_valid = 1'b0;
        req.w_valid  = 1'b0;
        check_eq("t1_b_not_yet", {31'd0, rsp.b_valid}, 32'd0);
        step();
        check_eq("t1_b_valid", {31'd0, rsp.b_valid}, 32'd1);
        check_eq("t1_b_resp", {30'd0, rsp.b.resp}, 32'd0);
        step();
        check_eq("t1_b_drop", {31'd0, rsp.b_valid}, 32'd0);
        req.ar.addr  = 32'h10;
        req.ar_valid = 1'b1;
        req.r_ready  = 1'b1;
        step();
        req.ar_valid = 1'b0;
        check_eq("t1_r_not_yet", {31'd0, rsp.r_valid}, 32'd0);
        step();
        check_eq("t1_r_valid", {31'd0, rsp.r_valid}, 32'd1);
        check_eq("t1_r_data", rsp.r.data, 32'hDEADBEEF);
        check_eq("t1_r_resp", {30'd0, rsp.r.resp}, 32'd0);
        step();
        check_eq("t1_r_drop", {31'd0, rsp.r_valid}, 32'd0);

        // 2: partial strobes and unaligned read
        do_write(32'h20, 32'h11223344, 4'hF, bresp);
        check_eq("t2_wr1_resp", {30'd0, bresp}, 32'd0);
        do_write(32'h20, 32'hAABBCCDD, 4'b0101, bresp);
        check_eq("t2_wr2_resp", {30'd0, bresp}, 32'd0);
        do_read(32'h20, rdata, rresp);
        check_eq("t2_rd_data", rdata, 32'h11BB33DD);
        check_eq("t2_rd_resp", {30'd0, rresp}, 32'd0);
        do_read(32'h22, rdata, rresp);
        check_eq("t2_rd_unaligned", rdata, 32'h11BB33DD);
        do_write(32'h20, 32'hFFFFFFFF, 4'h0, bresp);
        check_eq("t2_strb0_resp", {30'd0, bresp}, 32'd0);
        do_read(32'h20, rdata, rresp);
        check_eq("t2_strb0_data", rdata, 32'h11BB33DD);

        // 3: W ahead of AW, B stalled while a second pair fills the holding registers
        do_write(32'h0, 32'h600DF00D, 4'hF, bresp);
        req.b_ready  = 1'b0;
        req.w.data   = 32'h000000A1;
        req.w.strb   = 4'hF;
        req.w_valid  = 1'b1;
        step();
        req.w_valid  = 1'b0;
        check_eq("t3_w_ready_low", {31'd0, rsp.w_ready}, 32'd0);
        step();
        step();
        req.aw.addr  = 32'h30;
        req.aw_valid = 1'b1;
        step();
        req.aw_valid = 1'b0;
        check_eq("t3_b_not_yet", {31'd0, rsp.b_valid}, 32'd0);
        step();
        check_eq("t3_b_valid", {31'd0, rsp.b_valid}, 32'd1);
        check_eq("t3_b_resp", {30'd0, rsp.b.resp}, 32'd0);
        req.aw.addr  = 32'h1000;
        req.aw_valid = 1'b1;
        req.w.data   = 32'h000000B2;
        req.w_valid  = 1'b1;
        check_eq("t3_pair2_readies", {30'd0, rsp.aw_ready, rsp.w_ready}, 32'd3);
        step();
        req.aw_valid = 1'b0;
        req.w_valid  = 1'b0;
        for (int i = 0; i < 3; i++) begin
            check_eq("t3_hold_b_valid", {31'd0, rsp.b_valid}, 32'd1);
            check_eq("t3_hold_b_resp", {30'd0, rsp.b.resp}, 32'd0);
            check_eq("t3_hold_readies", {30'd0, rsp.aw_ready, rsp.w_ready}, 32'd0);
            step();
        end
        req.b_ready = 1'b1;
        step();
        check_eq("t3_b2_valid", {31'd0, rsp.b_valid}, 32'd1);
        check_eq("t3_b2_resp", {30'd0, rsp.b.resp}, 32'd2);
        step();
        check_eq("t3_b2_drop", {31'd0, rsp.b_valid}, 32'd0);
        do_read(32'h30, rdata, rresp);
        check_eq("t3_rd_first", rdata, 32'h000000A1);

        // 4: out-of-range decode leaves memory alone
        do_read(32'h0, rdata, rresp);
        check_eq("t4_word0_kept", rdata, 32'h600DF00D);
        do_read(32'h1000, rdata, rresp);
        check_eq("t4_oor_rd_data", rdata, 32'd0);
        check_eq("t4_oor_rd_resp", {30'd0, rresp}, 32'd2);
        do_write(32'h80000000, 32'h12345678, 4'hF, bresp);
        check_eq("t4_oor_wr_resp", {30'd0, bresp}, 32'd2);
        do_read(32'h80000000, rdata, rresp);
        check_eq("t4_oor_hi_data", rdata, 32'd0);
        check_eq("t4_oor_hi_resp", {30'd0, rresp}, 32'd2);
        do_read(32'h0, rdata, rresp);
        check_eq("t4_word0_still", rdata, 32'h600DF00D);

        // 5: same-edge write commit and read issue to word 3
        do_write(32'hC, 32'h7, 4'hF, bresp);
        req.aw.addr  = 32'hC;
        req.aw_valid = 1'b1;
        req.w.data   = 32'h5;
        req.w.strb   = 4'hF;
        req.w_valid  = 1'b1;
        req.ar.addr  = 32'hC;
        req.ar_valid = 1'b1;
        req.b_ready  = 1'b1;
        req.r_ready  = 1'b1;
        step();
        req.aw_valid = 1'b0;
        req.w_valid  = 1'b0;
        req.ar_valid = 1'b0;
        step();
        check_eq("t5_r_valid", {31'd0, rsp.r_valid}, 32'd1);
        check_eq("t5_r_old_data", rsp.r.data, 32'h7);
        check_eq("t5_b_valid", {31'd0, rsp.b_valid}, 32'd1);
        step();
        do_read(32'hC, rdata, rresp);
        check_eq("t5_r_new_data", rdata, 32'h5);

        // 6: async reset with B and R pending and AW held
        req.b_ready  = 1'b0;
        req.r_ready  = 1'b0;
        req.aw.addr  = 32'h40;
        req.aw_valid = 1'b1;
        req.w.data   = 32'h99;
        req.w_valid  = 1'b1;
        req.ar.addr  = 32'h40;
        req.ar_valid = 1'b1;
        step();
        req.w_valid  = 1'b0;
        req.ar_valid = 1'b0;
        req.aw_valid = 1'b0;
        step();
        check_eq("t6_pending", {30'd0, rsp.b_valid, rsp.r_valid}, 32'd3);
        req.aw.addr  = 32'h44;
        req.aw_valid = 1'b1;
        step();
        req.aw_valid = 1'b0;
        check_eq("t6_aw_full", {31'd0, rsp.aw_ready}, 32'd0);
        arst_n = 1'b0;
        #2;
        check_eq("t6_async_valids", {30'd0, rsp.b_valid, rsp.r_valid}, 32'd0);
        check_eq("t6_async_r_data", rsp.r.data, 32'd0);
        #10;
        arst_n = 1'b1;
        req.b_ready = 1'b1;
        req.r_ready = 1'b1;
        step();
        check_eq("t6_readies", {29'd0, rsp.aw_ready, rsp.w_ready, rsp.ar_ready}, 32'd7);
        req.w.data  = 32'h77;
        req.w_valid = 1'b1;
        step();
        req.w_valid = 1'b0;
        for (int i = 0; i < 3; i++) begin
            check_eq("t6_no_stale", {30'd0, rsp.b_valid, rsp.r_valid}, 32'd0);
            step();
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
